// File: rtl/hilo_divider.sv
// hilo_divider: iterative radix-2 restoring divider for DIV/DIVU in EX.
// Remainder goes to HI, quotient to LO; EX is stalled until the one-cycle
// div_ready_o pulse. Signed divides run on magnitudes with a sign fix-up
// applied as the result is registered.
module hilo_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic             ex_flush,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  output logic [WIDTH-1:0] hi_div_out,
  output logic [WIDTH-1:0] lo_div_out,
  output logic             div_ready_o,
  output logic             div_stallE
);

  typedef enum logic [1:0] {
    IDLE,
    ZERO,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits shift out of the MSB into rem.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvr;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // One restoring step plus operand magnitudes and final sign fix-up.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvr};
    q_bit   = ~diff[WIDTH];
    rem_nx  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx  = {dvd[WIDTH-2:0], q_bit};
    quo_fix = q_neg ? (~quo_nx + 1'b1) : quo_nx;
    rem_fix = r_neg ? (~rem_nx + 1'b1) : rem_nx;
    abs_a   = (div_signed_i && reg1_i[WIDTH-1]) ? (~reg1_i + 1'b1) : reg1_i;
    abs_b   = (div_signed_i && reg2_i[WIDTH-1]) ? (~reg2_i + 1'b1) : reg2_i;
  end

  // EX stall request: held while a requested divide has no result yet.
  always_comb begin
    div_stallE = div_start_i & ~div_ready_o & ~ex_flush;
  end

  // Divider FSM with registered HI/LO results and ready pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvr         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      hi_div_out  <= '0;
      lo_div_out  <= '0;
      div_ready_o <= 1'b0;
    end else begin
      div_ready_o <= 1'b0;
      if (ex_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (div_start_i) begin
              cnt <= '0;
              rem <= '0;
              if (reg2_i == '0) begin
                // Keep the raw dividend: it is returned unmodified as HI.
                dvd   <= reg1_i;
                dvr   <= '0;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
                state <= ZERO;
              end else begin
                dvd   <= abs_a;
                dvr   <= abs_b;
                q_neg <= div_signed_i & (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
                r_neg <= div_signed_i & reg1_i[WIDTH-1];
                state <= BUSY;
              end
            end
          end
          ZERO: begin
            hi_div_out  <= dvd;
            lo_div_out  <= '1;
            div_ready_o <= 1'b1;
            state       <= DONE;
          end
          BUSY: begin
            rem <= rem_nx;
            dvd <= quo_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
              hi_div_out  <= rem_fix;
              lo_div_out  <= quo_fix;
              div_ready_o <= 1'b1;
              state       <= DONE;
            end
          end
          DONE: begin
            // div_start_i still belongs to the finishing instruction here.
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: directed cases plus randomized
// divides checked against a plain-arithmetic reference model.
module tb_hilo_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        ready;
  logic        stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hilo_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .div_start_i (start),
    .div_signed_i(sgn),
    .ex_flush    (flush),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .hi_div_out  (hi),
    .lo_div_out  (lo),
    .div_ready_o (ready),
    .div_stallE  (stall)
  );

  // Reference: truncating division, remainder takes dividend sign,
  // divide by zero gives all-ones quotient and the raw dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge: drives a start and follows it to the ready pulse.
  // Leaves start high and returns at the negedge of the ready cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq,
                         input logic [31:0] er, input int elat,
                         input string name);
    int cyc;
    int stalls;
    bit seen;
    reg1  = a;
    reg2  = b;
    sgn   = s;
    start = 1'b1;
    #1;
    cyc    = 1;
    stalls = 0;
    seen   = 0;
    while (cyc <= 60 && !seen) begin
      if (ready === 1'b1) seen = 1;
      else begin
        if (stall === 1'b1) stalls++;
        @(negedge clk);
        cyc++;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: got no ready in 60 cycles, expected ready in cycle %0d", name, elat);
    end else begin
      tests++;
      if (cyc != elat) begin
        fails++;
        $display("FAIL %s latency: got cycle %0d expected cycle %0d", name, cyc, elat);
      end
      tests++;
      if (stalls != elat - 1) begin
        fails++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, elat - 1);
      end
      tests++;
      if (lo !== eq) begin
        fails++;
        $display("FAIL %s lo: got %h expected %h", name, lo, eq);
      end
      tests++;
      if (hi !== er) begin
        fails++;
        $display("FAIL %s hi: got %h expected %h", name, hi, er);
      end
      tests++;
      if (stall !== 1'b0) begin
        fails++;
        $display("FAIL %s stall_at_ready: got %b expected 0", name, stall);
      end
    end
  endtask

  // Drops start after a result and checks the pulse lasted one cycle.
  task automatic end_div(input string name);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL %s pulse_width: got ready %b expected 0", name, ready);
    end
  endtask

  // Watches n cycles and returns how many had ready high.
  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got hi=%h lo=%h ready=%b expected 0 0 0", hi, lo, ready);
    end
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_div(32'h64, 32'h7, 1'b0, 32'h0000_000E, 32'h0000_0002, 34, "divu_100_7");
    end_div("divu_100_7");
    run_div(32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, "div_m7_2");
    end_div("div_m7_2");
    run_div(32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 34, "div_7_m2");
    end_div("div_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 34, "div_ovf");
    end_div("div_ovf");
    run_div(32'hFFFF_FFFF, 32'h1, 1'b0, 32'hFFFF_FFFF, 32'h0, 34, "divu_max_1");
    end_div("divu_max_1");
    run_div(32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 3, "div_zero");
    end_div("div_zero");
    run_div(32'hF000_0001, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hF000_0001, 3, "div_zero_signed");
    end_div("div_zero_signed");
  endtask

  task automatic test_flush();
    logic [31:0] prev_hi, prev_lo;
    int n;
    prev_hi = hi;
    prev_lo = lo;
    reg1  = 32'h1000;
    reg2  = 32'h3;
    sgn   = 1'b0;
    start = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    flush = 1'b0;
    count_ready(40, n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL flush_no_ready: got %0d pulses expected 0", n);
    end
    tests++;
    if (hi !== prev_hi || lo !== prev_lo) begin
      fails++;
      $display("FAIL flush_hold: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, prev_hi, prev_lo);
    end
    run_div(32'h9, 32'h3, 1'b0, 32'h3, 32'h0, 34, "after_flush_9_3");
    end_div("after_flush_9_3");
    // Start coinciding with a flush must not be accepted.
    reg1  = 32'h50;
    reg2  = 32'h0;
    start = 1'b1;
    flush = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_start_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    count_ready(40, n);
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL flush_start_no_ready: got %0d pulses expected 0", n);
    end
  endtask

  task automatic test_async_reset();
    reg1  = 32'h0012_3456;
    reg2  = 32'h7;
    sgn   = 1'b0;
    start = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got hi=%h lo=%h ready=%b expected 0 0 0", hi, lo, ready);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_div(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 34, "after_reset_20_6");
    end_div("after_reset_20_6");
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    run_div(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 34, "b2b_first");
    // Keep start high with new operands through DONE; the next IDLE cycle
    // is cycle 1 of the second divide.
    reg1 = 32'hFFFF_FC18;
    reg2 = 32'd7;
    sgn  = 1'b1;
    @(negedge clk);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_pulse_width: got ready %b expected 0", ready);
    end
    model(32'hFFFF_FC18, 32'd7, 1'b1, q, r);
    run_div(32'hFFFF_FC18, 32'd7, 1'b1, q, r, 34, "b2b_second");
    end_div("b2b_second");
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic s;
    int k;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      k = $urandom_range(0, 7);
      case (k)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        3: begin b = $urandom; a = 32'h8000_0000; end
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, q, r);
      run_div(a, b, s, q, r, (b == 32'd0) ? 3 : 34, "random");
      end_div("random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hilo_divider.md
Name: hilo_divider

Overview:
- Iterative radix-2 restoring divider in the EX stage, serving DIV/DIVU.
- It is the inverse-operation counterpart of the EX-stage multiplier path: it takes the same two register operands, writes remainder to HI and quotient to LO, and stalls EX until the result is ready.
- The HI/LO write mux in EX selects hi_div_out/lo_div_out when the instruction is a divide.

Parameters:
- WIDTH, 32, operand and result width (HI/LO width).
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- div_start_i  in  1  divide requested by the instruction currently in EX; held high while EX is stalled.
- div_signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with the start.
- ex_flush  in  1  aborts any divide in progress.
- reg1_i  in  WIDTH  dividend; sampled on acceptance.
- reg2_i  in  WIDTH  divisor; sampled on acceptance.
- hi_div_out  out  WIDTH  remainder; valid while div_ready_o = 1.
- lo_div_out  out  WIDTH  quotient; valid while div_ready_o = 1.
- div_ready_o  out  1  one-cycle result-valid pulse.
- div_stallE  out  1  EX stall request, combinational.

Behaviour:
- Reset (rst_i = 0, asynchronous): state = IDLE, counter = 0, hi_div_out = 0, lo_div_out = 0, div_ready_o = 0. Reset mid-divide discards the operation.
- States: IDLE, ZERO, BUSY, DONE.
- IDLE:
  - If div_start_i = 1 and ex_flush = 0, latch operands and sign mode.
  - If the divisor is 0, go to ZERO; otherwise go to BUSY with counter = 0.
  - In signed mode, latch the absolute values and record q_neg = dividend[31] ^ divisor[31] and r_neg = dividend[31].
- BUSY, one quotient bit per cycle, MSB first:
  - Shift {rem, dvd} left by 1, then trial-subtract the divisor from rem.
  - If the trial difference is non-negative, rem = difference and the quotient bit = 1; else the quotient bit = 0.
  - Counter increments each cycle; after WIDTH iterations go to DONE.
- ZERO: lasts one cycle; result = quotient 0xFFFFFFFF, remainder = original dividend (no sign fix-up). Then go to DONE.
- DONE: lasts one cycle.
  - div_ready_o = 1.
  - Outputs present the final values: in signed mode, quotient is negated if q_neg and remainder is negated if r_neg.
  - Next state is always IDLE. div_start_i is ignored in DONE, because it still reflects the finishing instruction.
- Outputs hold their last values in IDLE. div_ready_o is 0 in every state except DONE.
- div_stallE = div_start_i & ~div_ready_o & ~ex_flush.
- Latency:
  - Normal divide: acceptance edge, then 32 BUSY cycles, then DONE. div_ready_o is high in the 34th cycle counting the accept cycle as cycle 1.
  - Divide by zero: div_ready_o is high in cycle 3.
- ex_flush = 1 in any state: the next state is IDLE, no div_ready_o pulse, and outputs are unchanged. A start in the same cycle as a flush is not accepted.
- Back-to-back divides: the second start is accepted in the IDLE cycle right after DONE.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the unsigned core; no special case.
- The core uses unsigned WIDTH-bit magnitudes and a (WIDTH+1)-bit trial subtract. There is no overflow output.

Test Plan:
- DIVU 100 / 7 (reg1_i = 0x64, reg2_i = 0x7) -> div_stallE high for 33 cycles; in cycle 34, div_ready_o = 1, lo_div_out = 0x0000000E, hi_div_out = 0x00000002.
- DIV -7 / 2 (0xFFFFFFF9, 0x2) -> lo_div_out = 0xFFFFFFFD, hi_div_out = 0xFFFFFFFF. DIV 7 / -2 -> lo_div_out = 0xFFFFFFFD, hi_div_out = 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_div_out = 0x80000000, hi_div_out = 0. DIVU 0xFFFFFFFF / 1 -> lo_div_out = 0xFFFFFFFF, hi_div_out = 0.
- Divisor 0, dividend 0x12345678 -> div_ready_o in cycle 3, lo_div_out = 0xFFFFFFFF, hi_div_out = 0x12345678.
- ex_flush pulsed in BUSY cycle 10 -> no div_ready_o pulse, state IDLE next cycle. A new DIVU 9 / 3 then completes with lo_div_out = 3, hi_div_out = 0.
- rst_i low asynchronously mid-BUSY -> outputs read 0 immediately. After release, a start of 20 / 6 gives lo_div_out = 3, hi_div_out = 2. Two back-to-back starts each produce exactly one div_ready_o pulse.
